// File: rtl/hazard_scheduler.sv
// hazard_scheduler: pipeline hazard unit for a 5-stage in-order core.
// Produces registered EX operand forwarding selects, a combinational
// load-use / multicycle stall, a branch flush (taken cycle plus one extra
// FLUSH2 cycle) and a busy flag for the multicycle mul/div unit.
// Optional build macro HAZARD_STATS_EN enables a saturating 16-bit counter
// of stalled clock edges on stall_cycles; without it stall_cycles is tied 0.
module hazard_scheduler #(
    parameter int REG_AW        = 5,
    parameter int MULDIV_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_muldiv,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_regwrite,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_regwrite,
    input  logic              branch_taken,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              stall,
    output logic              flush,
    output logic              busy,
    output logic [15:0]       stall_cycles
);

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        MDBUSY = 2'b01,
        FLUSH2 = 2'b10
    } state_t;

    // Counter reload: MDBUSY lasts MULDIV_CYCLES-1 cycles (cnt runs down to 1).
    localparam logic [2:0] MD_LOAD = 3'(MULDIV_CYCLES - 1);

    // A pipeline stage produces a forwardable value for src; r0 never does.
    function automatic logic stage_match(input logic              we,
                                         input logic [REG_AW-1:0] rd,
                                         input logic [REG_AW-1:0] src);
        return we && (rd == src) && (rd != {REG_AW{1'b0}});
    endfunction

    state_t      state_r, next_state_s;
    logic [2:0]  cnt_r, next_cnt_s;
    logic        stall_s, flush_s, busy_s;
    logic        ex_a_s, ex_b_s, mem_a_s, mem_b_s, load_use_s;
    logic [1:0]  sel_a_s, sel_b_s;

    assign ex_a_s     = stage_match(ex_regwrite, ex_rd, id_rs);
    assign ex_b_s     = stage_match(ex_regwrite, ex_rd, id_rt);
    assign mem_a_s    = stage_match(mem_regwrite, mem_rd, id_rs);
    assign mem_b_s    = stage_match(mem_regwrite, mem_rd, id_rt);
    assign load_use_s = ex_memread && (ex_a_s || ex_b_s);

    // Forwarding select choice: EX/MEM result is younger, so it wins over MEM/WB.
    always_comb begin
        sel_a_s = 2'b00;
        sel_b_s = 2'b00;
        if (ex_a_s) begin
            sel_a_s = 2'b10;
        end else if (mem_a_s) begin
            sel_a_s = 2'b01;
        end else begin
            sel_a_s = 2'b00;
        end
        if (ex_b_s) begin
            sel_b_s = 2'b10;
        end else if (mem_b_s) begin
            sel_b_s = 2'b01;
        end else begin
            sel_b_s = 2'b00;
        end
    end

    // Next-state and control outputs; branch beats load-use beats mul/div issue.
    always_comb begin
        next_state_s = state_r;
        next_cnt_s   = cnt_r;
        stall_s      = 1'b0;
        flush_s      = 1'b0;
        busy_s       = 1'b0;
        case (state_r)
            RUN: begin
                if (branch_taken) begin
                    flush_s      = 1'b1;
                    next_state_s = FLUSH2;
                end else if (load_use_s) begin
                    stall_s      = 1'b1;
                end else if (id_muldiv) begin
                    next_state_s = MDBUSY;
                    next_cnt_s   = MD_LOAD;
                end else begin
                    next_state_s = RUN;
                end
            end
            MDBUSY: begin
                if (branch_taken) begin
                    // Taken branch aborts the multicycle op.
                    flush_s      = 1'b1;
                    next_state_s = FLUSH2;
                    next_cnt_s   = 3'd0;
                end else begin
                    stall_s    = 1'b1;
                    busy_s     = 1'b1;
                    next_cnt_s = cnt_r - 3'd1;
                    if (cnt_r == 3'd1) begin
                        next_state_s = RUN;
                    end else begin
                        next_state_s = MDBUSY;
                    end
                end
            end
            FLUSH2: begin
                flush_s      = 1'b1;
                next_state_s = RUN;
            end
            default: begin
                next_state_s = RUN;
                next_cnt_s   = 3'd0;
            end
        endcase
    end

    // State and mul/div countdown register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= RUN;
            cnt_r   <= 3'd0;
        end else begin
            state_r <= next_state_s;
            cnt_r   <= next_cnt_s;
        end
    end

    // Forwarding selects: a stalled or flushed slot carries a bubble, so select regfile.
    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_a_sel <= 2'b00;
            fwd_b_sel <= 2'b00;
        end else if (!stall_s && !flush_s) begin
            fwd_a_sel <= sel_a_s;
            fwd_b_sel <= sel_b_s;
        end else begin
            fwd_a_sel <= 2'b00;
            fwd_b_sel <= 2'b00;
        end
    end

    assign stall = stall_s;
    assign flush = flush_s;
    assign busy  = busy_s;

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cnt_r;

    // Saturating count of clock edges seen with stall asserted.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= 16'h0000;
        end else if (stall_s && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'h0001;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cycles = stall_cnt_r;
`else
    assign stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed self-checking bench for hazard_scheduler (default parameters).
// Inputs change 1 ns after a rising edge; combinational outputs are
// checked on the falling edge, registered outputs 1 ns after the next rise.
module tb_hazard_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rd, mem_rd;
    logic        id_muldiv, ex_regwrite, ex_memread, mem_regwrite, branch_taken;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic        stall, flush, busy;
    logic [15:0] stall_cycles;

    int n_checks = 0;
    int n_errors = 0;

    hazard_scheduler #(.REG_AW(5), .MULDIV_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_muldiv(id_muldiv),
        .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .branch_taken(branch_taken),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .stall(stall), .flush(flush), .busy(busy),
        .stall_cycles(stall_cycles)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; id_muldiv = 1'b0;
        ex_rd = 5'd0; ex_regwrite = 1'b0; ex_memread = 1'b0;
        mem_rd = 5'd0; mem_regwrite = 1'b0; branch_taken = 1'b0;
    endtask

    task automatic check_ctl(input string tag, input logic s, input logic f, input logic b);
        @(negedge clk);
        check({tag, ".stall"}, {15'd0, stall}, {15'd0, s});
        check({tag, ".flush"}, {15'd0, flush}, {15'd0, f});
        check({tag, ".busy"},  {15'd0, busy},  {15'd0, b});
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        check("rst.fwd_a", {14'd0, fwd_a_sel}, 16'h0000);
        check("rst.fwd_b", {14'd0, fwd_b_sel}, 16'h0000);
        check("rst.stats", stall_cycles, 16'h0000);
        check_ctl("rst.ctl", 1'b0, 1'b0, 1'b0);

        // EX and MEM both match rs: EX has priority.
        step();
        ex_rd = 5'd5; ex_regwrite = 1'b1; mem_rd = 5'd5; mem_regwrite = 1'b1;
        id_rs = 5'd5; id_rt = 5'd3;
        check_ctl("exprio.ctl", 1'b0, 1'b0, 1'b0);
        step();
        check("exprio.fwd_a", {14'd0, fwd_a_sel}, 16'h0002);
        check("exprio.fwd_b", {14'd0, fwd_b_sel}, 16'h0000);

        // MEM-only match on rt.
        ex_regwrite = 1'b0; mem_rd = 5'd6; id_rt = 5'd6;
        step();
        check("memfwd.fwd_a", {14'd0, fwd_a_sel}, 16'h0000);
        check("memfwd.fwd_b", {14'd0, fwd_b_sel}, 16'h0001);

        // r0 never matches, even as a load destination.
        idle();
        ex_rd = 5'd0; ex_regwrite = 1'b1; ex_memread = 1'b1;
        mem_rd = 5'd0; mem_regwrite = 1'b1;
        check_ctl("r0.ctl", 1'b0, 1'b0, 1'b0);
        step();
        check("r0.fwd_a", {14'd0, fwd_a_sel}, 16'h0000);
        check("r0.fwd_b", {14'd0, fwd_b_sel}, 16'h0000);

        // EX match on rt, non-load.
        idle();
        ex_rd = 5'd9; ex_regwrite = 1'b1; id_rt = 5'd9;
        step();
        check("exb.fwd_b", {14'd0, fwd_b_sel}, 16'h0002);

        // Load-use on rt, with mul/div requested in the same cycle (held off).
        idle();
        ex_memread = 1'b1; ex_rd = 5'd7; ex_regwrite = 1'b1; id_rt = 5'd7;
        id_rs = 5'd1; mem_rd = 5'd1; mem_regwrite = 1'b1; id_muldiv = 1'b1;
        check_ctl("lduse.ctl", 1'b1, 1'b0, 1'b0);
        step();
        check("lduse.fwd_a", {14'd0, fwd_a_sel}, 16'h0000);
        check("lduse.fwd_b", {14'd0, fwd_b_sel}, 16'h0000);

        // Hazard gone, mul/div still requested: issue cycle is not stalled.
        idle();
        id_muldiv = 1'b1;
        check_ctl("mdissue.ctl", 1'b0, 1'b0, 1'b0);
        step();
        id_muldiv = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_ctl($sformatf("mdbusy%0d.ctl", i), 1'b1, 1'b0, 1'b1);
            step();
        end
        check_ctl("mddone.ctl", 1'b0, 1'b0, 1'b0);
`ifdef HAZARD_STATS_EN
        check("md.stats", stall_cycles, 16'd4);
`else
        check("md.stats", stall_cycles, 16'd0);
`endif

        // Branch during MDBUSY cycle 2 aborts the op.
        do_reset();
        id_muldiv = 1'b1;
        step();
        id_muldiv = 1'b0;
        check_ctl("mdabort.c1", 1'b1, 1'b0, 1'b1);
        step();
        branch_taken = 1'b1;
        ex_rd = 5'd4; ex_regwrite = 1'b1; id_rs = 5'd4;
        check_ctl("mdabort.br", 1'b0, 1'b1, 1'b0);
        step();
        check("mdabort.fwd_a", {14'd0, fwd_a_sel}, 16'h0000);
        branch_taken = 1'b0;
        check_ctl("mdabort.f2", 1'b0, 1'b1, 1'b0);
        step();
        check_ctl("mdabort.run", 1'b0, 1'b0, 1'b0);
`ifdef HAZARD_STATS_EN
        check("mdabort.stats", stall_cycles, 16'd1);
`else
        check("mdabort.stats", stall_cycles, 16'd0);
`endif
        step();
        check("postflush.fwd_a", {14'd0, fwd_a_sel}, 16'h0002);

        // Branch beats a simultaneous load-use in RUN.
        idle();
        ex_memread = 1'b1; ex_rd = 5'd8; ex_regwrite = 1'b1; id_rs = 5'd8;
        branch_taken = 1'b1;
        check_ctl("brprio.ctl", 1'b0, 1'b1, 1'b0);
        step();
        idle();
        check_ctl("brprio.f2", 1'b0, 1'b1, 1'b0);
        step();

        // Reset in the middle of MDBUSY.
        id_muldiv = 1'b1;
        step();
        id_muldiv = 1'b0;
        check_ctl("rstmd.busy", 1'b1, 1'b0, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_ctl("rstmd.after", 1'b0, 1'b0, 1'b0);
        check("rstmd.stats", stall_cycles, 16'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
